alu_mdu: RTL

- Parametrised successor to the single-cycle ALU: a WIDTH-bit integer execute unit with registered output and a valid/ready handshake.
- Adds XOR, SLL, SLT and SLTU to the ALU op set.
- Adds a multi-cycle multiply/divide path that writes internal HI/LO registers.
- Sits in the EX stage; the pipeline stalls on in_ready low.

---
 rtl/alu_mdu.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/alu_mdu.sv
// WIDTH-bit execute unit: single-cycle ALU ops plus a multi-cycle multiply/divide
// path writing HI/LO. Registered result with a one-cycle out_valid pulse.
module alu_mdu #(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int SHW  = $clog2(WIDTH);
   localparam int CMAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3;
   localparam logic [3:0] OP_SRL  = 4'd4,  OP_SRA  = 4'd5,  OP_XOR  = 4'd6,  OP_SLL  = 4'd7;
   localparam logic [3:0] OP_SLT  = 4'd8,  OP_SLTU = 4'd9,  OP_MULT = 4'd10, OP_MULTU = 4'd11;
   localparam logic [3:0] OP_DIV  = 4'd12, OP_DIVU = 4'd13, OP_MFHI = 4'd14, OP_MFLO = 4'd15;

   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   // Handshake: an op is taken on a rising edge where in_valid && in_ready;
   // in_ready is simply !busy, so requests during a multiply/divide are dropped.

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [WIDTH-1:0]  a_q, b_q;
   logic              div_q, uns_q;

   logic [SHW-1:0]    shamt;
   logic [WIDTH-1:0]  alu_res;
   logic              is_multi;
   logic [2*WIDTH-1:0] mul_a, mul_b, prod;
   logic [WIDTH-1:0]  mdu_hi, mdu_lo;

   assign busy     = (state == S_BUSY);
   assign in_ready = ~busy;
   assign shamt    = B[SHW-1:0];
   assign is_multi = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);

   always_comb begin
      alu_res = '0;
      case (op)
         OP_ADD:  alu_res = A + B;
         OP_SUB:  alu_res = A - B;
         OP_AND:  alu_res = A & B;
         OP_OR:   alu_res = A | B;
         OP_XOR:  alu_res = A ^ B;
         OP_SRL:  alu_res = A >> shamt;
         OP_SRA:  alu_res = $signed(A) >>> shamt;
         OP_SLL:  alu_res = A << shamt;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
         OP_MFHI: alu_res = hi;
         OP_MFLO: alu_res = lo;
         default: alu_res = '0;
      endcase
   end

   // Operands come only from the captured registers, so input wiggle during BUSY is harmless.
   always_comb begin
      mul_a  = uns_q ? {{WIDTH{1'b0}}, a_q} : {{WIDTH{a_q[WIDTH-1]}}, a_q};
      mul_b  = uns_q ? {{WIDTH{1'b0}}, b_q} : {{WIDTH{b_q[WIDTH-1]}}, b_q};
      prod   = mul_a * mul_b;
      mdu_hi = prod[2*WIDTH-1:WIDTH];
      mdu_lo = prod[WIDTH-1:0];
      if (div_q) begin
         if (b_q == '0) begin
            mdu_lo = ONES;
            mdu_hi = a_q;
         end else if (!uns_q && a_q == MIN_VAL && b_q == ONES) begin
            mdu_lo = MIN_VAL;
            mdu_hi = '0;
         end else if (!uns_q) begin
            mdu_lo = $signed(a_q) / $signed(b_q);
            mdu_hi = $signed(a_q) % $signed(b_q);
         end else begin
            mdu_lo = a_q / b_q;
            mdu_hi = a_q % b_q;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         a_q       <= '0;
         b_q       <= '0;
         div_q     <= 1'b0;
         uns_q     <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         hi        <= '0;
         lo        <= '0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  if (is_multi) begin
                     a_q   <= A;
                     b_q   <= B;
                     div_q <= op[2];
                     uns_q <= op[0];
                     cnt   <= op[2] ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                     state <= S_BUSY;
                  end else begin
                     result    <= alu_res;
                     out_valid <= 1'b1;
                  end
               end
            end
            S_BUSY: begin
               // Counter reaching 1 marks the edge that ends the Nth busy cycle.
               if (cnt == CW'(1)) begin
                  hi        <= mdu_hi;
                  lo        <= mdu_lo;
                  result    <= mdu_lo;
                  out_valid <= 1'b1;
                  cnt       <= '0;
                  state     <= S_IDLE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
